pace_sequencer: RTL and testbench

- Timing controller for the demand-pacing datapath. Sequences the pacing cycle through refractory, alert and pace phases, and issues fixed-width pace pulses when no intrinsic beat is sensed within the escape interval.
- Holds runtime-configurable timing (lower-rate interval, refractory period, pulse width) in shadow/active registers, so updates never corrupt a cycle in progress.
- Sits between the sense front-end (heartbeat_in) and the pacing output stage.

---
 rtl/pace_sequencer.sv | 143 ++++++++++++++
 tb/tb_pace_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pace_sequencer.sv
// Demand-pacing timing controller: refractory/alert/pace sequencing with
// shadowed runtime configuration and a synchronized intrinsic-beat input.
module pace_sequencer #(
    parameter int CNT_W      = 16,
    parameter int DEF_LRI    = 1000,
    parameter int DEF_RP     = 250,
    parameter int DEF_PW     = 2,
    parameter int HYST_TICKS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             enable,
    input  logic             heartbeat_in,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_lri,
    input  logic [CNT_W-1:0] cfg_rp,
    input  logic [7:0]       cfg_pw,
    output logic             pace_out,
    output logic             sense_evt,
    output logic             cfg_err,
    output logic [1:0]       state_o,
    output logic [15:0]      pace_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFRACT = 2'd1,
        ALERT   = 2'd2,
        PACE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic             sync1, sync2, sync2_d;
    logic             sense_edge;
    logic [CNT_W-1:0] timer, t_inc;
    logic [CNT_W-1:0] sh_lri, sh_rp, ac_lri, ac_rp;
    logic [7:0]       sh_pw, ac_pw;
    logic             last_sensed;
    logic [CNT_W:0]   esc;
    logic             cfg_ok;
    logic             pace_start, sense_acc, timer_clr;

    assign sense_edge = sync2 & ~sync2_d;
    assign state_o    = state;

    // Comparisons use the post-tick timer value so an interval of N ticks
    // expires on the clock that carries the Nth tick.
    assign t_inc = (tick && (timer != {CNT_W{1'b1}})) ? timer + CNT_W'(1) : timer;

    assign esc = {1'b0, ac_lri} + (last_sensed ? (CNT_W+1)'(HYST_TICKS) : '0);

    assign cfg_ok = (cfg_lri != '0) && (cfg_pw != '0) &&
                    (({1'b0, cfg_rp} + (CNT_W+1)'(cfg_pw)) < {1'b0, cfg_lri});

    always_comb begin
        state_nxt  = state;
        pace_start = 1'b0;
        sense_acc  = 1'b0;
        timer_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = REFRACT;
                    timer_clr = 1'b1;
                end
            end
            REFRACT: begin
                if (!enable)              state_nxt = IDLE;
                else if (t_inc >= ac_rp)  state_nxt = ALERT;
            end
            ALERT: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (sense_edge) begin
                    sense_acc = 1'b1;
                    timer_clr = 1'b1;
                    state_nxt = REFRACT;
                end else if ({1'b0, t_inc} >= esc) begin
                    pace_start = 1'b1;
                    timer_clr  = 1'b1;
                    state_nxt  = PACE;
                end
            end
            PACE: begin
                // Timer keeps running on exit: refractory counts from pace start.
                if (t_inc >= CNT_W'(ac_pw))
                    state_nxt = enable ? REFRACT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync2_d     <= 1'b0;
            timer       <= '0;
            sh_lri      <= CNT_W'(DEF_LRI);
            sh_rp       <= CNT_W'(DEF_RP);
            sh_pw       <= 8'(DEF_PW);
            ac_lri      <= CNT_W'(DEF_LRI);
            ac_rp       <= CNT_W'(DEF_RP);
            ac_pw       <= 8'(DEF_PW);
            last_sensed <= 1'b0;
            pace_out    <= 1'b0;
            sense_evt   <= 1'b0;
            cfg_err     <= 1'b0;
            pace_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            sync1     <= heartbeat_in;
            sync2     <= sync1;
            sync2_d   <= sync2;
            timer     <= timer_clr ? '0 : t_inc;
            pace_out  <= (state_nxt == PACE);
            sense_evt <= sense_acc;
            cfg_err   <= cfg_we & ~cfg_ok;
            pace_cnt  <= pace_cnt + 16'(pace_start);

            if (cfg_we && cfg_ok) begin
                sh_lri <= cfg_lri;
                sh_rp  <= cfg_rp;
                sh_pw  <= cfg_pw;
            end

            // Active copy takes the shadow as it stood before this edge, so a
            // write coinciding with an event lands at the following event.
            if ((state == IDLE) || pace_start || sense_acc) begin
                ac_lri <= sh_lri;
                ac_rp  <= sh_rp;
                ac_pw  <= sh_pw;
            end

            if (sense_acc)       last_sensed <= 1'b1;
            else if (pace_start) last_sensed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pace_sequencer.sv
// Directed bench for pace_sequencer: a HYST_TICKS=0 instance and a
// HYST_TICKS=3 instance share stimulus; expectations are hand-derived cycle counts.
module tb_pace_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, tick, enable, heartbeat_in, cfg_we;
    logic [15:0] cfg_lri, cfg_rp;
    logic [7:0]  cfg_pw;

    logic        pace_out, sense_evt, cfg_err;
    logic [1:0]  state_o;
    logic [15:0] pace_cnt;

    logic        h_pace_out, h_sense_evt, h_cfg_err;
    logic [1:0]  h_state_o;
    logic [15:0] h_pace_cnt;

    int checks   = 0;
    int failures = 0;

    pace_sequencer #(.HYST_TICKS(0)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
        .heartbeat_in(heartbeat_in), .cfg_we(cfg_we), .cfg_lri(cfg_lri),
        .cfg_rp(cfg_rp), .cfg_pw(cfg_pw), .pace_out(pace_out),
        .sense_evt(sense_evt), .cfg_err(cfg_err), .state_o(state_o),
        .pace_cnt(pace_cnt)
    );

    pace_sequencer #(.HYST_TICKS(3)) dut_h (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
        .heartbeat_in(heartbeat_in), .cfg_we(cfg_we), .cfg_lri(cfg_lri),
        .cfg_rp(cfg_rp), .cfg_pw(cfg_pw), .pace_out(h_pace_out),
        .sense_evt(h_sense_evt), .cfg_err(h_cfg_err), .state_o(h_state_o),
        .pace_cnt(h_pace_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [15:0] lri, input logic [15:0] rp, input logic [7:0] pw);
        cfg_we  = 1'b1;
        cfg_lri = lri;
        cfg_rp  = rp;
        cfg_pw  = pw;
        step();
        cfg_we  = 1'b0;
    endtask

    // Leaves the bench one edge after enable is seen (state REFRACT, timer 0).
    task automatic init_dut();
        rst_n = 1'b0; enable = 1'b0; cfg_we = 1'b0; heartbeat_in = 1'b0; tick = 1'b1;
        cfg_lri = '0; cfg_rp = '0; cfg_pw = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        write_cfg(16'd10, 16'd3, 8'd2);
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic wait_rise(input int limit, output int n);
        n = 0;
        while (pace_out !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; cfg_we = 1'b0; heartbeat_in = 1'b0; tick = 1'b1;
        cfg_lri = '0; cfg_rp = '0; cfg_pw = '0;
        step();
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        checks++; if (pace_out !== 1'b0) begin failures++; $display("FAIL reset_pace_out: got %b expected 0", pace_out); end
        checks++; if (sense_evt !== 1'b0) begin failures++; $display("FAIL reset_sense_evt: got %b expected 0", sense_evt); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        checks++; if (pace_cnt !== 16'd0) begin failures++; $display("FAIL reset_pace_cnt: got %0d expected 0", pace_cnt); end
    endtask

    task automatic test_free_run();
        int n;
        init_dut();
        checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL fr_start_state: got %0d expected 1", state_o); end
        wait_rise(20, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL fr_first_pace: got %0d cycles expected 10", n); end
        checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL fr_pace_state: got %0d expected 3", state_o); end
        checks++; if (pace_cnt !== 16'd1) begin failures++; $display("FAIL fr_cnt1: got %0d expected 1", pace_cnt); end
        step();
        checks++; if (pace_out !== 1'b1) begin failures++; $display("FAIL fr_pulse_hold: got %b expected 1", pace_out); end
        step();
        checks++; if (pace_out !== 1'b0) begin failures++; $display("FAIL fr_pulse_end: got %b expected 0", pace_out); end
        checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL fr_refract: got %0d expected 1", state_o); end
        step();
        checks++; if (state_o !== 2'd2) begin failures++; $display("FAIL fr_alert: got %0d expected 2", state_o); end
        wait_rise(20, n);
        checks++; if (n !== 7) begin failures++; $display("FAIL fr_period2: got %0d cycles expected 7", n); end
        checks++; if (pace_cnt !== 16'd2) begin failures++; $display("FAIL fr_cnt2: got %0d expected 2", pace_cnt); end
        step(); step();
        wait_rise(20, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL fr_period3: got %0d cycles expected 8", n); end
        checks++; if (pace_cnt !== 16'd3) begin failures++; $display("FAIL fr_cnt3: got %0d expected 3", pace_cnt); end
    endtask

    task automatic test_sense_alert();
        int n, r, rh;
        init_dut();
        wait_rise(20, n);
        step(); step(); step();
        heartbeat_in = 1'b1;
        step(); step();
        checks++; if (sense_evt !== 1'b0) begin failures++; $display("FAIL sa_latency_early: got %b expected 0", sense_evt); end
        step();
        checks++; if (sense_evt !== 1'b1) begin failures++; $display("FAIL sa_sense_evt: got %b expected 1", sense_evt); end
        checks++; if (h_sense_evt !== 1'b1) begin failures++; $display("FAIL sa_h_sense_evt: got %b expected 1", h_sense_evt); end
        checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL sa_state: got %0d expected 1", state_o); end
        step();
        checks++; if (sense_evt !== 1'b0) begin failures++; $display("FAIL sa_one_cycle: got %b expected 0", sense_evt); end
        heartbeat_in = 1'b0;
        r = 0; rh = 0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (pace_out === 1'b1 && r == 0) r = k;
            if (h_pace_out === 1'b1 && rh == 0) rh = k;
        end
        checks++; if (r !== 9) begin failures++; $display("FAIL sa_next_pace: got %0d expected 9", r); end
        checks++; if (rh !== 12) begin failures++; $display("FAIL sa_hyst_pace: got %0d expected 12", rh); end
        checks++; if (pace_cnt !== 16'd2) begin failures++; $display("FAIL sa_cnt: got %0d expected 2", pace_cnt); end
    endtask

    task automatic test_sense_refract();
        int n, r, saw;
        init_dut();
        wait_rise(20, n);
        heartbeat_in = 1'b1;
        r = 0; saw = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1) heartbeat_in = 1'b0;
            if (sense_evt === 1'b1) saw = 1;
            if (k > 2 && pace_out === 1'b1 && r == 0) r = k;
        end
        checks++; if (saw !== 0) begin failures++; $display("FAIL sr_no_sense: got %0d expected 0", saw); end
        checks++; if (r !== 10) begin failures++; $display("FAIL sr_pace_kept: got %0d expected 10", r); end
    endtask

    task automatic test_sense_at_expiry();
        int n;
        init_dut();
        wait_rise(20, n);
        for (int k = 0; k < 7; k++) step();
        heartbeat_in = 1'b1;
        step(); step(); step();
        checks++; if (sense_evt !== 1'b1) begin failures++; $display("FAIL se_sense_evt: got %b expected 1", sense_evt); end
        checks++; if (pace_out !== 1'b0) begin failures++; $display("FAIL se_no_pace: got %b expected 0", pace_out); end
        checks++; if (pace_cnt !== 16'd1) begin failures++; $display("FAIL se_cnt: got %0d expected 1", pace_cnt); end
        checks++; if (state_o !== 2'd1) begin failures++; $display("FAIL se_state: got %0d expected 1", state_o); end
        heartbeat_in = 1'b0;
        wait_rise(20, n);
        checks++; if (n !== 10) begin failures++; $display("FAIL se_next_pace: got %0d expected 10", n); end
    endtask

    task automatic test_cfg_update();
        int n;
        init_dut();
        for (int k = 0; k < 5; k++) step();
        write_cfg(16'd20, 16'd3, 8'd2);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cu_err: got %b expected 0", cfg_err); end
        wait_rise(20, n);
        checks++; if (n !== 4) begin failures++; $display("FAIL cu_old_interval: got %0d expected 4", n); end
        step(); step();
        wait_rise(30, n);
        checks++; if (n !== 18) begin failures++; $display("FAIL cu_new_interval: got %0d expected 18", n); end
    endtask

    task automatic test_cfg_reject();
        logic [15:0] lri_v [3] = '{16'd10, 16'd0, 16'd10};
        logic [15:0] rp_v  [3] = '{16'd8,  16'd3, 16'd3};
        logic [7:0]  pw_v  [3] = '{8'd2,   8'd2,  8'd0};
        int n;
        init_dut();
        for (int i = 0; i < 3; i++) begin
            write_cfg(lri_v[i], rp_v[i], pw_v[i]);
            checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cr_err_%0d: got %b expected 1", i, cfg_err); end
        end
        step();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cr_err_clear: got %b expected 0", cfg_err); end
        wait_rise(20, n);
        checks++; if (n !== 6) begin failures++; $display("FAIL cr_timing1: got %0d expected 6", n); end
        step(); step();
        wait_rise(20, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL cr_timing2: got %0d expected 8", n); end
        write_cfg(16'd10, 16'd7, 8'd2);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cr_boundary_ok: got %b expected 0", cfg_err); end
    endtask

    task automatic test_reset_mid_pulse();
        int n;
        init_dut();
        wait_rise(20, n);
        step();
        rst_n = 1'b0;
        #1;
        checks++; if (pace_out !== 1'b0) begin failures++; $display("FAIL rm_pace_out: got %b expected 0", pace_out); end
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL rm_state: got %0d expected 0", state_o); end
        checks++; if (pace_cnt !== 16'd0) begin failures++; $display("FAIL rm_cnt: got %0d expected 0", pace_cnt); end
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_enable_mid_pulse();
        int n;
        init_dut();
        wait_rise(20, n);
        enable = 1'b0;
        step();
        checks++; if (pace_out !== 1'b1) begin failures++; $display("FAIL em_hold: got %b expected 1", pace_out); end
        checks++; if (state_o !== 2'd3) begin failures++; $display("FAIL em_pace_state: got %0d expected 3", state_o); end
        step();
        checks++; if (pace_out !== 1'b0) begin failures++; $display("FAIL em_end: got %b expected 0", pace_out); end
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL em_idle: got %0d expected 0", state_o); end
        step();
        checks++; if (state_o !== 2'd0) begin failures++; $display("FAIL em_stay_idle: got %0d expected 0", state_o); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_sense_alert();
        test_sense_refract();
        test_sense_at_expiry();
        test_cfg_update();
        test_cfg_reject();
        test_reset_mid_pulse();
        test_enable_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
